// File: rtl/fifo_mem_mc.sv
// Single-clock multi-channel FIFO: one shared array split into NCH rings of 2^ASIZE words.
// Define FIFO_MEM_MC_STICKY_ERR_EN to make ovf/udf sticky until err_clr.
module fifo_mem_mc #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4,
  parameter int NCH   = 4,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic                     wr_en,
  input  logic [CW-1:0]            wr_ch,
  input  logic [DSIZE-1:0]         wdata,
  input  logic                     rd_en,
  input  logic [CW-1:0]            rd_ch,
  output logic [DSIZE-1:0]         rdata,
  output logic                     rvalid,
  output logic [NCH-1:0]           full,
  output logic [NCH-1:0]           empty,
  output logic [NCH*(ASIZE+1)-1:0] level,
  output logic                     ovf,
  output logic                     udf,
  input  logic                     err_clr
);

  localparam int DEPTH = 1 << ASIZE;
  localparam int LW    = ASIZE + 1;
  localparam logic [CW:0]   NCH_C   = (CW+1)'(NCH);
  localparam logic [LW-1:0] DEPTH_C = LW'(DEPTH);

  logic [DSIZE-1:0] mem_q [NCH*DEPTH];
  logic [ASIZE-1:0] wptr_q [NCH];
  logic [ASIZE-1:0] wptr_d [NCH];
  logic [ASIZE-1:0] rptr_q [NCH];
  logic [ASIZE-1:0] rptr_d [NCH];
  logic [LW-1:0]    cnt_q  [NCH];
  logic [LW-1:0]    cnt_d  [NCH];

  logic [DSIZE-1:0]      rdata_q;
  logic                  rvalid_q;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;
  logic [NCH-1:0]        wr_sel, rd_sel;
  logic [CW+ASIZE-1:0]   waddr, raddr;

  always_comb begin
    full  = '0;
    empty = '0;
    level = '0;
    for (int i = 0; i < NCH; i++) begin
      full[i]            = (cnt_q[i] == DEPTH_C);
      empty[i]           = (cnt_q[i] == '0);
      level[i*LW +: LW]  = cnt_q[i];
    end
  end

  // Acceptance uses pre-edge flags, so a full channel pops before it can take a push.
  always_comb begin
    wr_acc = 1'b0;
    rd_acc = 1'b0;
    waddr  = '0;
    raddr  = '0;
    if (wr_en && ({1'b0, wr_ch} < NCH_C)) begin
      wr_acc = !full[wr_ch];
      waddr  = {wr_ch, wptr_q[wr_ch]};
    end
    if (rd_en && ({1'b0, rd_ch} < NCH_C)) begin
      rd_acc = !empty[rd_ch];
      raddr  = {rd_ch, rptr_q[rd_ch]};
    end
    wr_sel = wr_acc ? (NCH'(1) << wr_ch) : '0;
    rd_sel = rd_acc ? (NCH'(1) << rd_ch) : '0;
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wptr_d[i] = wptr_q[i] + ASIZE'(wr_sel[i]);
      rptr_d[i] = rptr_q[i] + ASIZE'(rd_sel[i]);
      cnt_d[i]  = cnt_q[i] + LW'(wr_sel[i]) - LW'(rd_sel[i]);
    end
`ifdef FIFO_MEM_MC_STICKY_ERR_EN
    ovf_d = (wr_en && !wr_acc) || (ovf_q && !err_clr);
    udf_d = (rd_en && !rd_acc) || (udf_q && !err_clr);
`else
    ovf_d = wr_en && !wr_acc;
    udf_d = rd_en && !rd_acc;
`endif
  end

`ifndef FIFO_MEM_MC_STICKY_ERR_EN
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

  always_ff @(posedge wclk) begin
    if (wr_acc) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < NCH; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      if (rd_acc) rdata_q <= mem_q[raddr];
      rvalid_q <= rd_acc;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;

endmodule

// File: tb/tb_fifo_mem_mc.sv
// Randomized bench for fifo_mem_mc against a queue-per-channel reference model.
module tb_fifo_mem_mc;
  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int NCH   = 4;
  localparam int CW    = 2;
  localparam int DEPTH = 1 << ASIZE;
  localparam int LW    = ASIZE + 1;

  logic              wclk = 1'b0;
  logic              wrst_n;
  logic              wr_en, rd_en, err_clr;
  logic [CW-1:0]     wr_ch, rd_ch;
  logic [DSIZE-1:0]  wdata, rdata;
  logic              rvalid, ovf, udf;
  logic [NCH-1:0]    full, empty;
  logic [NCH*LW-1:0] level;

  fifo_mem_mc #(.DSIZE(DSIZE), .ASIZE(ASIZE), .NCH(NCH)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wdata(wdata),
    .rd_en(rd_en), .rd_ch(rd_ch), .rdata(rdata), .rvalid(rvalid), .full(full),
    .empty(empty), .level(level), .ovf(ovf), .udf(udf), .err_clr(err_clr)
  );

  always #5 wclk = ~wclk;

  logic [DSIZE-1:0] mq [NCH][$];
  logic [DSIZE-1:0] exp_rdata;
  logic             exp_rvalid, exp_ovf, exp_udf;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_state();
    logic [LW-1:0] lv;
    chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
    chk("rdata", 32'(rdata), 32'(exp_rdata));
    chk("ovf", 32'(ovf), 32'(exp_ovf));
    chk("udf", 32'(udf), 32'(exp_udf));
    for (int c = 0; c < NCH; c++) begin
      lv = level[c*LW +: LW];
      chk($sformatf("level%0d", c), 32'(lv), 32'(mq[c].size()));
      chk($sformatf("full%0d", c), 32'(full[c]), 32'(mq[c].size() == DEPTH));
      chk($sformatf("empty%0d", c), 32'(empty[c]), 32'(mq[c].size() == 0));
    end
  endtask

  task automatic step(input logic we, input int wc, input logic [7:0] wd,
                      input logic re, input int rc, input logic ec);
    logic wa, ra;
    wr_en = we; wr_ch = CW'(wc); wdata = wd;
    rd_en = re; rd_ch = CW'(rc); err_clr = ec;
    wa = we && (wc < NCH) && (mq[wc].size() < DEPTH);
    ra = re && (rc < NCH) && (mq[rc].size() > 0);
    @(posedge wclk);
    #1;
    if (ra) exp_rdata = mq[rc].pop_front();
    if (wa) mq[wc].push_back(wd);
    exp_rvalid = ra;
`ifdef FIFO_MEM_MC_STICKY_ERR_EN
    exp_ovf = (we && !wa) || (exp_ovf && !ec);
    exp_udf = (re && !ra) || (exp_udf && !ec);
`else
    exp_ovf = we && !wa;
    exp_udf = re && !ra;
`endif
    chk_state();
  endtask

  task automatic idle();
    step(1'b0, 0, 8'h00, 1'b0, 0, 1'b0);
  endtask

  // Reset lands mid-cycle; outputs must clear before the next clock edge.
  task automatic do_reset();
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    #2 wrst_n = 1'b0;
    #1;
    for (int c = 0; c < NCH; c++) mq[c].delete();
    exp_rdata = '0; exp_rvalid = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
    chk_state();
    @(posedge wclk);
    #1 wrst_n = 1'b1;
    chk_state();
  endtask

  initial begin
    wrst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    wr_ch = '0; rd_ch = '0; wdata = '0;
    exp_rdata = '0; exp_rvalid = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
    #1;
    do_reset();

    step(1'b1, 2, 8'h11, 1'b0, 0, 1'b0);
    step(1'b1, 2, 8'h22, 1'b0, 0, 1'b0);
    step(1'b1, 2, 8'h33, 1'b0, 0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 0, 8'h00, 1'b1, 2, 1'b0);
    chk("tp1_last", 32'(rdata), 32'h33);

    for (int k = 0; k < DEPTH; k++) step(1'b1, 0, 8'(8'h40 + k), 1'b0, 0, 1'b0);
    step(1'b1, 0, 8'hEE, 1'b0, 0, 1'b0);
    chk("tp2_ovf", 32'(ovf), 32'h1);
    for (int k = 0; k < DEPTH; k++) step(1'b0, 0, 8'h00, 1'b1, 0, 1'b0);

    for (int k = 0; k < DEPTH; k++) step(1'b1, 1, 8'(8'h80 + k), 1'b0, 0, 1'b0);
    step(1'b1, 1, 8'hAA, 1'b1, 1, 1'b0);
    chk("tp3_rd", 32'(rdata), 32'h80);

    step(1'b1, 3, 8'h5C, 1'b1, 3, 1'b0);
    step(1'b0, 0, 8'h00, 1'b1, 3, 1'b0);
    chk("tp4_rd", 32'(rdata), 32'h5C);
    idle();

    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 1), 8'($urandom),
           1'($urandom_range(0, 1)), $urandom_range(0, 1), 1'b0);

    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 0, 8'(8'hC0 + k), 1'b0, 0, 1'b0);
    do_reset();
    step(1'b0, 0, 8'h00, 1'b1, 0, 1'b0);
    chk("rst_udf", 32'(udf), 32'h1);
    idle();
    idle();
    step(1'b0, 0, 8'h00, 1'b0, 0, 1'b1);
    idle();

    for (int k = 0; k < 600; k++)
      step(1'($urandom_range(0, 3) != 0), $urandom_range(0, NCH-1), 8'($urandom),
           1'($urandom_range(0, 2) != 0), $urandom_range(0, NCH-1),
           1'($urandom_range(0, 7) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
